// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: access sizes, FSM states
// and requester ids.
package mem_arb_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and a byte/half/word access:
// store byte enables and lane replication, load extraction and extension.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[7:0];
    case (offset)
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      2'd3:    lane_b = rdata[31:24];
      default: lane_b = rdata[7:0];
    endcase
  end

  assign lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      end
      SZ_H: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        misaligned = offset[0];
      end
      SZ_W: begin
        be         = 4'b1111;
        misaligned = |offset;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (I) and load/store (D).
// state  | meaning
// IDLE   | accepting requests, grant is combinational
// ACCESS | mem_en strobe with registered address/enables/data
// WAIT   | down-counting read latency, capture steered data at zero
// RESP   | one-cycle rvalid to the owning port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_t state;
  logic       last_winner;
  logic       owner;
  logic       r_we;
  logic [1:0] r_size;
  logic [1:0] r_off;
  logic       r_uns;
  logic [1:0] wait_cnt;

  logic        win_d;
  logic        win_i;
  logic        is_idle;
  logic [1:0]  al_size;
  logic [1:0]  al_off;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata_rep;
  logic [31:0] al_rdata_ext;
  logic        al_mis;

  logic [2*(30-ADDR_W)+1:0] unused_addr;
  assign unused_addr = {if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

  // D wins alone, or on a tie when I went last
  assign is_idle = (state == ST_IDLE);
  assign win_d   = d_req & (~if_req | (last_winner == PORT_I));
  assign win_i   = if_req & ~win_d;
  assign if_gnt  = is_idle & win_i;
  assign d_gnt   = is_idle & win_d;

  // The aligner sees the live D request while granting, the registered one afterwards
  always_comb begin
    al_size = r_size;
    al_off  = r_off;
    al_uns  = r_uns;
    if (is_idle) begin
      al_size = win_d ? d_size : SZ_W;
      al_off  = win_d ? d_addr[1:0] : 2'b00;
      al_uns  = win_d & d_unsigned;
    end
  end

  mem_lane_align u_align (
    .size        (al_size),
    .offset      (al_off),
    .is_unsigned (al_uns),
    .wdata       (d_wdata),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata_rep   (al_wdata_rep),
    .rdata_ext   (al_rdata_ext),
    .misaligned  (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_winner <= PORT_I;
      owner       <= PORT_I;
      r_we        <= 1'b0;
      r_size      <= SZ_B;
      r_off       <= 2'b00;
      r_uns       <= 1'b0;
      wait_cnt    <= 2'd0;
      if_rvalid   <= 1'b0;
      if_rdata    <= 32'd0;
      d_rvalid    <= 1'b0;
      d_rdata     <= 32'd0;
      d_err       <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_gnt || d_gnt) begin
            last_winner <= d_gnt ? PORT_D : PORT_I;
            owner       <= d_gnt ? PORT_D : PORT_I;
            r_we        <= d_gnt & d_we;
            r_size      <= al_size;
            r_off       <= al_off;
            r_uns       <= al_uns;
            mem_addr    <= d_gnt ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
            mem_be      <= al_be;
            mem_wdata   <= al_wdata_rep;
            if (d_gnt && al_mis) begin
              state    <= ST_RESP;
              d_rvalid <= 1'b1;
              d_rdata  <= 32'd0;
              d_err    <= 1'b1;
            end else begin
              state  <= ST_ACCESS;
              mem_en <= 1'b1;
              mem_we <= d_gnt & d_we;
            end
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            state    <= ST_RESP;
            d_rvalid <= 1'b1;
            d_rdata  <= 32'd0;
            d_err    <= 1'b0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= 2'(RD_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state <= ST_RESP;
            if (owner == PORT_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= al_rdata_ext;
              d_err    <= 1'b0;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= al_rdata_ext;
            end
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_if_hold: assert property (@(posedge clk) disable iff (!rst_n) (if_req && !if_gnt) |=> if_req);
  a_d_hold:  assert property (@(posedge clk) disable iff (!rst_n) (d_req && !d_gnt) |=> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: byte-level memory model predicts grants, memory strobes and responses.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with RD_LAT = 1
  logic          rst_n, if_req, if_gnt, if_rvalid;
  logic [31:0]   if_addr, if_rdata;
  logic          d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
  logic [1:0]    d_size;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  // DUT with RD_LAT = 3
  logic          rst3_n, i3_req, i3_gnt, i3_rvalid;
  logic [31:0]   i3_addr, i3_rdata;
  logic          d3_req, d3_we, d3_unsigned, d3_gnt, d3_rvalid, d3_err;
  logic [1:0]    d3_size;
  logic [31:0]   d3_addr, d3_wdata, d3_rdata;
  logic          m3_en, m3_we;
  logic [3:0]    m3_be;
  logic [AW-1:0] m3_addr;
  logic [31:0]   m3_wdata, m3_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .RD_LAT(L1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .RD_LAT(L3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .if_req(i3_req), .if_addr(i3_addr), .if_gnt(i3_gnt), .if_rvalid(i3_rvalid), .if_rdata(i3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_size(d3_size), .d_unsigned(d3_unsigned), .d_addr(d3_addr),
    .d_wdata(d3_wdata), .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata), .d_err(d3_err),
    .mem_en(m3_en), .mem_we(m3_we), .mem_be(m3_be), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory device for the RD_LAT=1 DUT, with a backdoor for preloading
  logic [31:0]   sim_mem [1024];
  logic          bd_we;
  logic [AW-1:0] bd_idx;
  logic [31:0]   bd_val;
  logic [31:0]   pd [3];
  logic          pv [3];
  always @(posedge clk) begin
    if (bd_we) sim_mem[bd_idx] <= bd_val;
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sim_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    pv[0] <= mem_en && !mem_we;
    pd[0] <= sim_mem[mem_addr];
    for (int s = 1; s < 3; s++) begin
      pv[s] <= pv[s-1];
      pd[s] <= pd[s-1];
    end
  end
  assign mem_rdata = pv[L1-1] ? pd[L1-1] : 32'h5A5A_C3C3;

  // Memory device for the RD_LAT=3 DUT: contents are a function of the word address
  logic [31:0] pd3 [3];
  logic        pv3 [3];
  always @(posedge clk) begin
    pv3[0] <= m3_en && !m3_we;
    pd3[0] <= 32'hC0DE_0000 | {22'd0, m3_addr};
    for (int s = 1; s < 3; s++) begin
      pv3[s] <= pv3[s-1];
      pd3[s] <= pd3[s-1];
    end
  end
  assign m3_rdata = pv3[L3-1] ? pd3[L3-1] : 32'h5A5A_C3C3;

  // Reference model: byte-addressed memory, serialized transactions
  typedef struct {int cyc; logic [31:0] data; logic err;} resp_t;
  typedef struct {int cyc; logic [AW-1:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} macc_t;
  logic [7:0] model_bytes [4096];
  resp_t q_i[$];
  resp_t q_d[$];
  macc_t q_m[$];
  logic pend_i = 1'b0, pend_d = 1'b0;
  logic last_was_d = 1'b0;
  int   free_cyc = 0;

  task automatic model_grant_i(int t);
    logic [11:0] ba;
    logic [31:0] v;
    ba = {if_addr[11:2], 2'b00};
    for (int k = 0; k < 4; k++) v[8*k +: 8] = model_bytes[int'(ba) + k];
    q_m.push_back('{t + 1, if_addr[11:2], 4'hF, 1'b0, 32'd0});
    q_i.push_back('{t + 2 + L1, v, 1'b0});
    free_cyc = t + 3 + L1;
  endtask

  task automatic model_grant_d(int t);
    int n;
    logic [11:0] ba;
    logic [31:0] v, wexp;
    logic [3:0]  be;
    n  = (d_size == 2'b00) ? 1 : (d_size == 2'b01) ? 2 : 4;
    ba = d_addr[11:0];
    if (d_size == 2'b11 || (int'(ba) % n) != 0) begin
      q_d.push_back('{t + 1, 32'd0, 1'b1});
      free_cyc = t + 2;
    end else begin
      be = 4'b0000;
      for (int k = 0; k < n; k++) be[int'(ba[1:0]) + k] = 1'b1;
      if (d_we) begin
        for (int k = 0; k < n; k++) model_bytes[int'(ba) + k] = d_wdata[8*k +: 8];
        wexp = (n == 1) ? {4{d_wdata[7:0]}} : (n == 2) ? {2{d_wdata[15:0]}} : d_wdata;
        q_m.push_back('{t + 1, ba[11:2], be, 1'b1, wexp});
        q_d.push_back('{t + 2, 32'd0, 1'b0});
        free_cyc = t + 3;
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = model_bytes[int'(ba) + k];
        if (!d_unsigned && n < 4 && v[8*n-1])
          for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        q_m.push_back('{t + 1, ba[11:2], be, 1'b0, 32'd0});
        q_d.push_back('{t + 2 + L1, v, 1'b0});
        free_cyc = t + 3 + L1;
      end
    end
  endtask

  task automatic issue_i(logic [31:0] a);
    if_req = 1'b1; if_addr = a; pend_i = 1'b1;
  endtask

  task automatic issue_d(logic we, logic [1:0] sz, logic uns, logic [31:0] a, logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd; pend_d = 1'b1;
  endtask

  // One cycle: check grants at the negedge, update requests just after the posedge
  task automatic step();
    logic egi, egd;
    bit   can;
    @(negedge clk);
    can = (cyc >= free_cyc);
    egd = can && pend_d && (!pend_i || !last_was_d);
    egi = can && pend_i && !egd;
    if (pend_i || pend_d || if_gnt || d_gnt) begin
      checks++;
      if ({if_gnt, d_gnt} !== {egi, egd}) begin
        errors++;
        $display("FAIL grant cyc=%0d: if_gnt/d_gnt got %b%b want %b%b", cyc, if_gnt, d_gnt, egi, egd);
      end
    end
    if (egd) begin model_grant_d(cyc); pend_d = 1'b0; last_was_d = 1'b1; end
    if (egi) begin model_grant_i(cyc); pend_i = 1'b0; last_was_d = 1'b0; end
    @(posedge clk); #1;
    if (!pend_i) if_req = 1'b0;
    if (!pend_d) d_req = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((pend_i || pend_d || cyc < free_cyc) && k < 100) begin step(); k++; end
    if (pend_i || pend_d || cyc < free_cyc) begin
      checks++; errors++;
      $display("FAIL drain timeout at cyc=%0d", cyc);
    end
  endtask

  task automatic set_word(int idx, logic [31:0] val);
    bd_idx = AW'(idx); bd_val = val; bd_we = 1'b1;
    for (int b = 0; b < 4; b++) model_bytes[4*idx + b] = val[8*b +: 8];
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents an access or a response
  initial begin
    macc_t m;
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_en) begin
          checks++;
          if (q_m.size() == 0) begin
            errors++; $display("FAIL mem_access unexpected cyc=%0d addr=%0h", cyc, mem_addr);
          end else begin
            m = q_m.pop_front();
            if (m.cyc != cyc || mem_addr !== m.addr || mem_be !== m.be || mem_we !== m.we ||
                (m.we && mem_wdata !== m.wdata)) begin
              errors++;
              $display("FAIL mem_access cyc=%0d got addr=%0h be=%b we=%b wd=%h want cyc=%0d addr=%0h be=%b we=%b wd=%h",
                       cyc, mem_addr, mem_be, mem_we, mem_wdata, m.cyc, m.addr, m.be, m.we, m.wdata);
            end
          end
        end
        if (if_rvalid) begin
          checks++;
          if (q_i.size() == 0) begin
            errors++; $display("FAIL if_resp unexpected cyc=%0d data=%h", cyc, if_rdata);
          end else begin
            r = q_i.pop_front();
            if (r.cyc != cyc || if_rdata !== r.data) begin
              errors++;
              $display("FAIL if_resp got cyc=%0d data=%h want cyc=%0d data=%h", cyc, if_rdata, r.cyc, r.data);
            end
          end
        end
        if (d_rvalid) begin
          checks++;
          if (q_d.size() == 0) begin
            errors++; $display("FAIL d_resp unexpected cyc=%0d data=%h err=%b", cyc, d_rdata, d_err);
          end else begin
            r = q_d.pop_front();
            if (r.cyc != cyc || d_rdata !== r.data || d_err !== r.err) begin
              errors++;
              $display("FAIL d_resp got cyc=%0d data=%h err=%b want cyc=%0d data=%h err=%b",
                       cyc, d_rdata, d_err, r.cyc, r.data, r.err);
            end
          end
        end
      end
    end
  end

  function automatic logic [31:0] or_outs1();
    return {31'd0, if_gnt | if_rvalid | d_gnt | d_rvalid | d_err | mem_en | mem_we} |
           if_rdata | d_rdata | mem_wdata | {28'd0, mem_be} | {22'd0, mem_addr};
  endfunction

  function automatic logic [31:0] or_outs3();
    return {31'd0, i3_gnt | i3_rvalid | d3_gnt | d3_rvalid | d3_err | m3_en | m3_we} |
           i3_rdata | d3_rdata | m3_wdata | {28'd0, m3_be} | {22'd0, m3_addr};
  endfunction

  initial begin
    logic [31:0] w, a;
    int t, rv_cyc, rv_cnt;
    logic [31:0] rv_data;
    rst_n = 1'b0; rst3_n = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
    d_unsigned = 1'b0; d_addr = '0; d_wdata = '0; bd_we = 1'b0; bd_idx = '0; bd_val = '0;
    i3_req = 1'b0; i3_addr = '0; d3_req = 1'b0; d3_we = 1'b0; d3_size = 2'b00;
    d3_unsigned = 1'b0; d3_addr = '0; d3_wdata = '0;

    for (int i = 0; i < 1024; i++) set_word(i, $urandom);

    checks++;
    if (or_outs1() !== 32'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", or_outs1()); end
    rst_n = 1'b1;

    // Tie straight out of reset: D then I
    issue_i(32'h0000_0044); issue_d(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'd0);
    drain();
    for (int r = 0; r < 3; r++) begin
      issue_i(32'h0000_0100 + 32'(4*r)); issue_d(1'b0, 2'b10, 1'b0, 32'h0000_0200 + 32'(4*r), 32'd0);
      drain();
    end

    set_word(4, 32'hDEAD_BEEF);
    issue_i(32'h0000_0010); drain();
    issue_d(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5); drain();
    set_word(32'h40, 32'h8001_7FFF);
    issue_d(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'd0); drain();
    issue_d(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'd0); drain();
    issue_d(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'd0); drain();
    issue_d(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'd0); drain();
    issue_d(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0); drain();
    issue_d(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'd0); drain();
    issue_d(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h1234_5678); drain();
    issue_d(1'b1, 2'b01, 1'b0, 32'hFFFF_F102, 32'h1234_BEEF); drain();
    issue_d(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0); drain();

    for (int n = 0; n < 500; n++) begin
      if (!pend_i && $urandom_range(2) == 0) issue_i($urandom);
      if (!pend_d && $urandom_range(1) == 0) begin
        a = $urandom;
        a[11:6] = 6'd0;
        w = $urandom;
        issue_d(1'($urandom_range(1)), ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2)),
                1'($urandom_range(1)), a, w);
      end
      step();
    end
    drain();

    // RD_LAT=3 instance: reset during WAIT, then a clean fetch
    checks++;
    if (or_outs3() !== 32'd0) begin errors++; $display("FAIL reset3_outputs got %h want 0", or_outs3()); end
    rst3_n = 1'b1; i3_req = 1'b1; i3_addr = 32'h0000_0040;
    @(negedge clk);
    checks++;
    if (i3_gnt !== 1'b1) begin errors++; $display("FAIL first_gnt3 got %b want 1", i3_gnt); end
    @(posedge clk); #1; i3_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m3_en !== 1'b1 || m3_addr !== 10'd16) begin
      errors++; $display("FAIL access3 got en=%b addr=%0d want en=1 addr=16", m3_en, m3_addr);
    end
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    checks++;
    if (or_outs3() !== 32'd0) begin errors++; $display("FAIL reset_in_wait got %h want 0", or_outs3()); end
    rv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (i3_rvalid || d3_rvalid) rv_cnt++;
    end
    checks++;
    if (rv_cnt != 0) begin errors++; $display("FAIL dropped_txn rvalid_count got %0d want 0", rv_cnt); end
    @(posedge clk); #1;
    rst3_n = 1'b1; i3_req = 1'b1; i3_addr = 32'h0000_0020;
    @(negedge clk);
    t = cyc;
    checks++;
    if (i3_gnt !== 1'b1) begin errors++; $display("FAIL regrant3 got %b want 1", i3_gnt); end
    @(posedge clk); #1; i3_req = 1'b0;
    rv_cnt = 0; rv_cyc = -1; rv_data = 32'd0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (i3_rvalid) begin
        rv_cnt++;
        if (rv_cyc < 0) begin rv_cyc = cyc; rv_data = i3_rdata; end
      end
    end
    checks++;
    if (rv_cnt != 1 || rv_cyc != t + 5 || rv_data !== 32'hC0DE_0008) begin
      errors++;
      $display("FAIL fetch3 got count=%0d at=%0d data=%h want count=1 at=%0d data=c0de0008",
               rv_cnt, rv_cyc, rv_data, t + 5);
    end

    checks++;
    if (q_i.size() != 0 || q_d.size() != 0 || q_m.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations i=%0d d=%0d m=%0d want 0", q_i.size(), q_d.size(), q_m.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
